// File: rtl/z80_io_uart_tx_if.sv
// Z80 I/O bus slice seen by the UART transmitter: strobes, address, write data and status readback.
interface z80_io_uart_tx_if;
    logic       iorq;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output iorq, output write, output addr, output wdata, input rdata);
    modport slave  (input iorq, input write, input addr, input wdata, output rdata);
endinterface

// File: rtl/z80_io_uart_tx.sv
// I/O-mapped 8N1 UART transmitter for the tv80 CPU: OUT to DATA_PORT queues a byte,
// IN from STATUS_PORT returns {4'b0, overflow, busy, empty, full}.
module z80_io_uart_tx #(
    parameter int         CLK_HZ      = 12000000,
    parameter int         BAUD        = 115200,
    parameter logic [7:0] DATA_PORT   = 8'h00,
    parameter logic [7:0] STATUS_PORT = 8'h01,
    parameter int         FIFO_DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    z80_io_uart_tx_if.slave         bus,
    output logic                    tx,
    output logic                    irq_n
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          wr_hit_reg, rd_hit_reg;
    logic          overflow_reg;
    logic [1:0]    state_reg;
    logic [CW-1:0] baud_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          irq_n_reg;
    logic [7:0]    rdata_reg;

    logic wr_hit, rd_hit, wr_edge, rd_fall;
    logic fifo_empty, fifo_full, busy;
    logic pop, push, drop, bit_end;

    assign wr_hit     = bus.iorq &  bus.write & (bus.addr == DATA_PORT);
    assign rd_hit     = bus.iorq & ~bus.write & (bus.addr == STATUS_PORT);
    assign wr_edge    = wr_hit & ~wr_hit_reg;
    assign rd_fall    = ~rd_hit & rd_hit_reg;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign busy       = (state_reg != ST_IDLE);
    assign bit_end    = (baud_cnt_reg == CW'(CLKS_PER_BIT - 1));

    // A full FIFO still accepts a byte when the shifter frees a slot in the same cycle.
    assign pop        = (state_reg == ST_IDLE) & ~fifo_empty;
    assign push       = wr_edge & (~fifo_full | pop);
    assign drop       = wr_edge & ~push;

    assign tx         = tx_reg;
    assign irq_n      = irq_n_reg;
    assign bus.rdata  = rdata_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            wr_hit_reg   <= 1'b0;
            rd_hit_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            rdata_reg    <= 8'h00;
            irq_n_reg    <= 1'b0;
        end else begin
            wr_hit_reg <= wr_hit;
            rd_hit_reg <= rd_hit;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A drop coinciding with the read-side clear keeps the flag set.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (rd_fall) begin
                overflow_reg <= 1'b0;
            end
            if (rd_hit) begin
                rdata_reg <= {4'b0000, overflow_reg, busy, fifo_empty, fifo_full};
            end
            irq_n_reg <= ~(fifo_empty & ~busy);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= 8'h00;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg    <= mem[rd_ptr_reg];
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b0;
                        state_reg    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= shift_reg[0];
                        state_reg    <= ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= ST_STOP;
                        end else begin
                            // Present the next bit from the pre-shift copy so tx stays flop-driven.
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    tx_reg <= 1'b1;
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_z80_io_uart_tx.sv
// Directed bench for z80_io_uart_tx at 4 clocks per bit with a 4-entry FIFO.
module tb_z80_io_uart_tx;
    localparam int         CLK_HZ      = 1000000;
    localparam int         BAUD        = 250000;
    localparam int         FIFO_DEPTH  = 4;
    localparam logic [7:0] DATA_PORT   = 8'h00;
    localparam logic [7:0] STATUS_PORT = 8'h01;

    logic clk;
    logic reset;
    logic tx;
    logic irq_n;

    z80_io_uart_tx_if bus_if ();

    z80_io_uart_tx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .DATA_PORT   (DATA_PORT),
        .STATUS_PORT (STATUS_PORT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .tx    (tx),
        .irq_n (irq_n)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        bus_if.iorq  = 1'b1;
        bus_if.write = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        tick;
        bus_if.iorq  = 1'b0;
        bus_if.write = 1'b0;
        tick;
        $display("[TB] OUT (%02h),%02h at cycle %0d", a, d, cyc);
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        bus_if.iorq  = 1'b1;
        bus_if.write = 1'b0;
        bus_if.addr  = a;
        tick;
        d = bus_if.rdata;
        bus_if.iorq  = 1'b0;
        tick;
        $display("[TB] IN (%02h) -> %02h at cycle %0d", a, d, cyc);
    endtask

    task automatic wait_start(input int max_ticks, output int waited, output bit found);
        waited = 0;
        while (tx !== 1'b0 && waited < max_ticks) begin
            tick;
            waited++;
        end
        found = (tx === 1'b0);
    endtask

    task automatic wait_irq_low(input int max_ticks, output int waited, output bit found);
        waited = 0;
        while (irq_n !== 1'b0 && waited < max_ticks) begin
            tick;
            waited++;
        end
        found = (irq_n === 1'b0);
    endtask

    // Entered on the first start-bit clock; samples all 40 clocks of the frame.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [3:0] obs [10];
        logic [9:0] expb;
        logic       irq_mid;
        expb    = {1'b1, b, 1'b0};
        irq_mid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) tick;
            obs[i / 4][i % 4] = tx;
            if (i == 20) irq_mid = irq_n;
        end
        for (int n = 0; n < 10; n++) begin
            check($sformatf("%s_bit%0d", tag, n), 32'(obs[n]), expb[n] ? 32'hF : 32'h0);
        end
        check($sformatf("%s_irq_mid", tag), 32'(irq_mid), 32'd1);
        $display("[TB] frame %02h checked at cycle %0d", b, cyc);
    endtask

    initial begin
        int         w;
        bit         f;
        int         e0;
        logic [7:0] rd;

        reset        = 1'b1;
        bus_if.iorq  = 1'b0;
        bus_if.write = 1'b0;
        bus_if.addr  = 8'h00;
        bus_if.wdata = 8'h00;
        tick; tick; tick;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_rdata", 32'(bus_if.rdata), 32'h00);
        check("rst_irq_n", 32'(irq_n), 32'd0);
        reset = 1'b0;
        tick;

        // 1: single byte 0x55
        io_write(DATA_PORT, 8'h55);
        wait_start(5, w, f);
        check("t1_latency", 32'(w), 32'd0);
        check_frame(8'h55, "t1");
        wait_irq_low(10, w, f);
        check("t1_irq_low_delay", 32'(w), 32'd2);

        // 2: OUT strobe held for 6 clocks yields one frame only
        bus_if.iorq  = 1'b1;
        bus_if.write = 1'b1;
        bus_if.addr  = DATA_PORT;
        bus_if.wdata = 8'hA3;
        fork
            begin
                repeat (6) @(posedge clk);
                #1;
                bus_if.iorq  = 1'b0;
                bus_if.write = 1'b0;
            end
        join_none
        wait_start(10, w, f);
        check("t2_start_delay", 32'(w), 32'd2);
        check_frame(8'hA3, "t2");
        wait_start(60, w, f);
        check("t2_no_second_frame", 32'(f), 32'd0);

        // 3: shifter busy with 0xFF, then five OUTs overrun the 4-entry FIFO
        io_write(DATA_PORT, 8'hFF);
        for (int k = 1; k <= 5; k++) begin
            io_write(DATA_PORT, 8'(k));
        end
        io_read(STATUS_PORT, rd);
        check("t3_status_ovf", 32'(rd), 32'h0D);
        io_read(STATUS_PORT, rd);
        check("t3_status_cleared", 32'(rd), 32'h05);
        for (int k = 1; k <= 4; k++) begin
            wait_start((k == 1) ? 60 : 5, w, f);
            check($sformatf("t3_start%0d", k), 32'(f), 32'd1);
            if (k > 1) check($sformatf("t3_gap%0d", k), 32'(w), 32'd2);
            check_frame(8'(k), $sformatf("t3_b%0d", k));
        end
        wait_start(60, w, f);
        check("t3_byte5_dropped", 32'(f), 32'd0);

        // 4: push into a full FIFO on the exact cycle the shifter pops
        io_write(DATA_PORT, 8'hFF);
        e0 = cyc;
        for (int k = 1; k <= 4; k++) begin
            io_write(DATA_PORT, 8'hB0 + 8'(k));
        end
        while (cyc < e0 + 40) tick;
        bus_if.iorq  = 1'b1;
        bus_if.write = 1'b1;
        bus_if.addr  = DATA_PORT;
        bus_if.wdata = 8'hC5;
        tick;
        check("t4_pop_start", 32'(tx), 32'd0);
        bus_if.iorq  = 1'b0;
        bus_if.write = 1'b0;
        tick;
        io_read(STATUS_PORT, rd);
        check("t4_status", 32'(rd), 32'h05);
        wait_irq_low(400, w, f);
        check("t4_drain_cycles", 32'(cyc - e0), 32'd246);

        // 5: reset in clock 14 of a 0xF0 frame with another byte queued
        io_write(DATA_PORT, 8'hF0);
        e0 = cyc;
        io_write(DATA_PORT, 8'h99);
        while (cyc < e0 + 13) tick;
        check("t5_tx_before_rst", 32'(tx), 32'd0);
        reset = 1'b1;
        #1;
        check("t5_tx_async", 32'(tx), 32'd1);
        check("t5_rdata_rst", 32'(bus_if.rdata), 32'h00);
        check("t5_irq_rst", 32'(irq_n), 32'd0);
        tick;
        reset = 1'b0;
        wait_start(60, w, f);
        check("t5_no_resume", 32'(f), 32'd0);
        io_read(STATUS_PORT, rd);
        check("t5_status", 32'(rd), 32'h02);

        // 6: status while busy, reads of other ports, OUT to a non-data port
        io_write(DATA_PORT, 8'h3C);
        io_read(STATUS_PORT, rd);
        check("t6_status_busy", 32'(rd), 32'h06);
        wait_irq_low(60, w, f);
        check("t6_irq_low", 32'(f), 32'd1);
        io_read(8'h07, rd);
        check("t6_other_port_hold", 32'(rd), 32'h06);
        io_read(STATUS_PORT, rd);
        check("t6_status_idle", 32'(rd), 32'h02);
        io_write(8'h05, 8'h00);
        wait_start(20, w, f);
        check("t6_wrong_port_no_tx", 32'(f), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
